// File: rtl/alu_mul_seq.sv
// Iterative shift-and-add multiplier. It retires one multiplier bit per clock and
// delivers a 2*WIDTH-bit signed or unsigned product with an overflow flag.
module alu_mul_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] in_0,
   input  logic [WIDTH-1:0] in_1,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_hi,
   output logic             overflow
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t             state, next_state;
   logic [WIDTH-1:0]   mcand, mplier;
   logic [2*WIDTH-1:0] acc;
   logic [CNT_W-1:0]   cnt;
   logic               neg, sgn;

   logic               accept, last_bit;
   logic [WIDTH-1:0]   mag_0, mag_1, addend;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod;
   logic               prod_ovf;

   // A flush in the same cycle as start (IDLE or DONE) drops the request.
   assign accept   = ((state == IDLE) || (state == DONE)) && start && !flush;
   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   // NOTE: state uses non-blocking assignments so every register samples the pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_) state <= IDLE;
      else         state <= next_state;
   end

   // NOTE: next_state gets a default first so no path through the case can infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept) next_state = CALC;
         CALC: begin
            if (flush)         next_state = IDLE;
            else if (last_bit) next_state = FIX;
         end
         FIX:  next_state = flush ? IDLE : DONE;
         DONE: next_state = accept ? CALC : IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == CALC) || (state == FIX);
      done = (state == DONE);
   end

   // Signed operands are reduced to magnitudes; -2^(W-1) maps onto itself, which is
   // exactly the unsigned value 2^(W-1).
   always_comb begin
      mag_0    = (signed_op && in_0[WIDTH-1]) ? -in_0 : in_0;
      mag_1    = (signed_op && in_1[WIDTH-1]) ? -in_1 : in_1;
      addend   = mplier[0] ? mcand : '0;
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      prod     = neg ? -acc : acc;
      prod_ovf = sgn ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                     : (prod[2*WIDTH-1:WIDTH] != '0);
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         cnt      <= '0;
         neg      <= 1'b0;
         sgn      <= 1'b0;
         out      <= '0;
         out_hi   <= '0;
         overflow <= 1'b0;
      end else if (accept) begin
         mcand  <= mag_0;
         mplier <= mag_1;
         neg    <= signed_op & (in_0[WIDTH-1] ^ in_1[WIDTH-1]);
         sgn    <= signed_op;
         acc    <= '0;
         cnt    <= '0;
      end else if ((state == CALC) && !flush) begin
         // Carry out of the upper half lands in the MSB after the right shift.
         acc    <= {sum, acc[WIDTH-1:1]};
         mplier <= mplier >> 1;
         cnt    <= cnt + CNT_W'(1);
      end else if ((state == FIX) && !flush) begin
         out      <= prod[WIDTH-1:0];
         out_hi   <= prod[2*WIDTH-1:WIDTH];
         overflow <= prod_ovf;
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: stimulus pushes hand-computed products with
// their expected done edge, and a negedge monitor pops and compares on each done pulse.
module tb_alu_mul_seq;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         ovf;
      int           done_edge;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset_ = 1'b0;
   logic         start = 1'b0;
   logic         signed_op = 1'b0;
   logic [W-1:0] in_0 = '0;
   logic [W-1:0] in_1 = '0;
   logic         flush = 1'b0;
   logic         busy, done, overflow;
   logic [W-1:0] out, out_hi;

   exp_t sb[$];
   int   edge_cnt = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   alu_mul_seq #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .reset_(reset_), .start(start), .signed_op(signed_op),
      .in_0(in_0), .in_1(in_1), .flush(flush), .busy(busy), .done(done),
      .out(out), .out_hi(out_hi), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // After edge n has passed, edge_cnt reads n at the following negedge.
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         check("done_has_pending", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("out",       64'(out),      64'(e.lo));
            check("out_hi",    64'(out_hi),   64'(e.hi));
            check("overflow",  64'(overflow), 64'(e.ovf));
            check("done_edge", 64'(edge_cnt), 64'(e.done_edge));
         end
      end
   end

   // Called at a negedge; the request is sampled at the next edge (E0 = s).
   task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] lo, input logic [W-1:0] hi, input logic ovf,
                        input bit push_it, output int s);
      exp_t e;
      start = 1'b1; signed_op = sgn; in_0 = a; in_1 = b;
      s = edge_cnt + 1;
      if (push_it) begin
         e.lo = lo; e.hi = hi; e.ovf = ovf; e.done_edge = s + 33;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0; signed_op = ~sgn; in_0 = $urandom; in_1 = $urandom;
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      while (sb.size() != 0 && k < 100) begin
         @(negedge clk); #1;
         k++;
      end
      check(name, 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   task automatic wait_until(input int n);
      while (edge_cnt < n) @(negedge clk);
   endtask

   initial begin
      int s;

      // Power-on reset
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_out", 64'(out), 64'd0);
      check("rst_out_hi", 64'(out_hi), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      reset_ = 1'b1;
      @(negedge clk);

      // Signed 7 x -3 with busy window checks
      issue(1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 1'b1, s);
      check("busy_e0", 64'(busy), 64'd1);
      wait_until(s + 32);
      check("busy_e32", 64'(busy), 64'd1);
      check("done_e32", 64'(done), 64'd0);
      @(negedge clk);
      check("busy_e33", 64'(busy), 64'd0);
      wait_done("to_7x-3");

      // Reset sampled at E10 of an operation discards it and clears outputs
      issue(1'b0, 32'd9, 32'd9, '0, '0, 1'b0, 1'b0, s);
      wait_until(s + 9);
      reset_ = 1'b0;
      @(negedge clk);
      reset_ = 1'b1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_out", 64'(out), 64'd0);
      check("midrst_out_hi", 64'(out_hi), 64'd0);
      check("midrst_ovf", 64'(overflow), 64'd0);
      issue(1'b1, 32'hFFFF_FFFB, 32'd4, 32'hFFFF_FFEC, 32'hFFFF_FFFF, 1'b0, 1'b1, s);
      wait_done("to_-5x4");

      // Directed products, issued back-to-back from the DONE cycle
      issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b1, s);
      wait_done("to_umax_sq");
      issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, s);
      wait_done("to_m1_sq");
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, s);
      wait_done("to_min_x_m1");
      issue(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b1, 1'b1, s);
      wait_done("to_min_sq");
      issue(1'b0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 32'h0000_0001, 1'b1, 1'b1, s);
      wait_done("to_shift4");
      issue(1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, s);
      wait_done("to_zero");
      issue(1'b1, 32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0000, 1'b1, 1'b1, s);
      wait_done("to_smax_x2");
      issue(1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, s);
      wait_done("to_2p32");

      // start held high with operands changing every cycle: only E0 and E34 accepted
      s = edge_cnt + 1;
      for (int i = 0; i <= 34; i++) begin
         exp_t e;
         start = 1'b1; signed_op = 1'b0; in_0 = 32'(100 + i); in_1 = 32'd1000;
         if (i == 0) begin
            e.lo = 32'd100000; e.hi = '0; e.ovf = 1'b0; e.done_edge = s + 33;
            sb.push_back(e);
         end
         if (i == 34) begin
            e.lo = 32'd134000; e.hi = '0; e.ovf = 1'b0; e.done_edge = s + 34 + 33;
            sb.push_back(e);
         end
         @(negedge clk);
      end
      start = 1'b0;
      wait_until(s + 50);
      check("hs_out_stable", 64'(out), 64'd100000);
      check("hs_busy", 64'(busy), 64'd1);
      wait_done("to_handshake");

      // flush sampled at E15: no done pulse, previous result retained
      issue(1'b0, 32'd3, 32'd5, '0, '0, 1'b0, 1'b0, s);
      wait_until(s + 14);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush15_busy", 64'(busy), 64'd0);
      check("flush15_out", 64'(out), 64'd134000);
      repeat (25) @(negedge clk);

      // flush sampled at the FIX edge: outputs are not updated
      issue(1'b0, 32'd3, 32'd5, '0, '0, 1'b0, 1'b0, s);
      wait_until(s + 32);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flushfix_busy", 64'(busy), 64'd0);
      check("flushfix_done", 64'(done), 64'd0);
      check("flushfix_out", 64'(out), 64'd134000);
      check("flushfix_ovf", 64'(overflow), 64'd0);

      // flush with start in IDLE: request dropped
      @(negedge clk);
      start = 1'b1; flush = 1'b1; in_0 = 32'd2; in_1 = 32'd2;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flushstart_busy", 64'(busy), 64'd0);
      repeat (40) @(negedge clk);
      check("flushstart_out", 64'(out), 64'd134000);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
